// File: rtl/text_overlay_engine.sv
// text_overlay_engine: two-stage pipelined 5x7 glyph line renderer for VGA.
// Define TEXT_OVERLAY_BLINK_EN to enable frame-counted text blinking.
module text_overlay_engine #(
  parameter int SCALE        = 3,
  parameter int MAX_CHARS    = 16,
  parameter int AW           = 4,
  parameter int BLINK_FRAMES = 30
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_valid,
  input  logic [9:0]    pixel_x,
  input  logic [9:0]    pixel_y,
  input  logic [9:0]    origin_x,
  input  logic [9:0]    origin_y,
  input  logic [11:0]   fg_color,
  input  logic          frame_start,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [5:0]    wr_char,
  output logic          busy,
  output logic          text_valid,
  output logic          is_text_pixel,
  output logic [11:0]   text_color
);

  localparam logic [9:0]    CELL_W  = 10'(7 * SCALE);
  localparam logic [9:0]    SC      = 10'(SCALE);
  localparam logic [9:0]    SLOTS   = 10'(MAX_CHARS);
  localparam logic [AW:0]   SLOTS_A = (AW + 1)'(MAX_CHARS);
  localparam logic [AW-1:0] LAST    = AW'(MAX_CHARS - 1);
  localparam logic [5:0]    SPACE   = 6'd63;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          busy_q, busy_d;

  logic [5:0]    buf_q [2**AW];
  logic          buf_we;
  logic [AW-1:0] buf_wa;
  logic [5:0]    buf_wd;

  // Clear sequencer: fills every slot with space, then hands the port to wr_*.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    buf_we  = 1'b0;
    buf_wa  = wr_addr;
    buf_wd  = wr_char;
    unique case (state_q)
      CLEAR: begin
        buf_we = 1'b1;
        buf_wa = ptr_q;
        buf_wd = SPACE;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == LAST) begin
          state_d = RUN;
          busy_d  = 1'b0;
          ptr_d   = '0;
        end
      end
      RUN: buf_we = wr_en && ({1'b0, wr_addr} < SLOTS_A);
      default: ;
    endcase
  end

  // FSM state, clear pointer and busy flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  // Line buffer write port; reads are combinational so S2 sees the old char.
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[buf_wa] <= buf_wd;
  end

  logic [9:0]    rel_x, rel_y, slot_full;
  logic          s1_valid_d, s1_valid_q;
  logic          s1_hit_d, s1_hit_q;
  logic [AW-1:0] s1_slot_d, s1_slot_q;
  logic [2:0]    s1_col_d, s1_col_q;
  logic [2:0]    s1_row_d, s1_row_q;
  logic [11:0]   s1_fg_d, s1_fg_q;

  // S1: map the pixel into slot / glyph column / glyph row and box test.
  always_comb begin
    rel_x      = pixel_x - origin_x;
    rel_y      = pixel_y - origin_y;
    slot_full  = rel_x / CELL_W;
    s1_slot_d  = AW'(slot_full);
    s1_col_d   = 3'((rel_x % CELL_W) / SC);
    s1_row_d   = 3'(rel_y / SC);
    s1_valid_d = pix_valid;
    s1_fg_d    = fg_color;
    s1_hit_d   = pix_valid
              && (pixel_x >= origin_x)
              && (pixel_y >= origin_y)
              && (rel_y < CELL_W)
              && (slot_full < SLOTS)
              && (s1_col_d < 3'd5);
  end

  // S1 pipeline registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_hit_q   <= 1'b0;
      s1_slot_q  <= '0;
      s1_col_q   <= '0;
      s1_row_q   <= '0;
      s1_fg_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_hit_q   <= s1_hit_d;
      s1_slot_q  <= s1_slot_d;
      s1_col_q   <= s1_col_d;
      s1_row_q   <= s1_row_d;
      s1_fg_q    <= s1_fg_d;
    end
  end

  function automatic logic [34:0] font(input logic [5:0] c);
    logic [34:0] g;
    g = '0;
    case (c)
      6'd0:  g = 35'b01110_10001_10001_11111_10001_10001_10001;
      6'd1:  g = 35'b11110_10001_10001_11110_10001_10001_11110;
      6'd2:  g = 35'b01110_10001_10000_10000_10000_10001_01110;
      6'd3:  g = 35'b11110_10001_10001_10001_10001_10001_11110;
      6'd4:  g = 35'b11111_10000_10000_11110_10000_10000_11111;
      6'd5:  g = 35'b11111_10000_10000_11110_10000_10000_10000;
      6'd6:  g = 35'b01110_10001_10000_10111_10001_10001_01111;
      6'd7:  g = 35'b10001_10001_10001_11111_10001_10001_10001;
      6'd8:  g = 35'b01110_00100_00100_00100_00100_00100_01110;
      6'd9:  g = 35'b00111_00010_00010_00010_00010_10010_01100;
      6'd10: g = 35'b10001_10010_10100_11000_10100_10010_10001;
      6'd11: g = 35'b10000_10000_10000_10000_10000_10000_11111;
      6'd12: g = 35'b10001_11011_10101_10101_10001_10001_10001;
      6'd13: g = 35'b10001_10001_11001_10101_10011_10001_10001;
      6'd14: g = 35'b01110_10001_10001_10001_10001_10001_01110;
      6'd15: g = 35'b11110_10001_10001_11110_10000_10000_10000;
      6'd16: g = 35'b01110_10001_10001_10001_10101_10010_01101;
      6'd17: g = 35'b11110_10001_10001_11110_10100_10010_10001;
      6'd18: g = 35'b01111_10000_10000_01110_00001_00001_11110;
      6'd19: g = 35'b11111_00100_00100_00100_00100_00100_00100;
      6'd20: g = 35'b10001_10001_10001_10001_10001_10001_01110;
      6'd21: g = 35'b10001_10001_10001_10001_10001_01010_00100;
      6'd22: g = 35'b10001_10001_10001_10101_10101_10101_01010;
      6'd23: g = 35'b10001_10001_01010_00100_01010_10001_10001;
      6'd24: g = 35'b10001_10001_10001_01010_00100_00100_00100;
      6'd25: g = 35'b11111_00001_00010_00100_01000_10000_11111;
      6'd26: g = 35'b01110_10001_10011_10101_11001_10001_01110;
      6'd27: g = 35'b00100_01100_00100_00100_00100_00100_01110;
      6'd28: g = 35'b01110_10001_00001_00010_00100_01000_11111;
      6'd29: g = 35'b11111_00010_00100_00010_00001_10001_01110;
      6'd30: g = 35'b00010_00110_01010_10010_11111_00010_00010;
      6'd31: g = 35'b11111_10000_11110_00001_00001_10001_01110;
      6'd32: g = 35'b00110_01000_10000_11110_10001_10001_01110;
      6'd33: g = 35'b11111_00001_00010_00100_01000_01000_01000;
      6'd34: g = 35'b01110_10001_10001_01110_10001_10001_01110;
      6'd35: g = 35'b01110_10001_10001_01111_00001_00010_01100;
      default: g = '0;
    endcase
    return g;
  endfunction

  logic show;

`ifdef TEXT_OVERLAY_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BW-1:0] fcnt_q, fcnt_d;
  logic          phase_q, phase_d;

  // Count frame pulses; flip visibility every BLINK_FRAMES frames.
  always_comb begin
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (frame_start) begin
      if (fcnt_q == BW'(BLINK_FRAMES - 1)) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // Blink counter and phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
    end
  end

  assign show = ~phase_q;
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
  assign show = 1'b1;
`endif

  logic [5:0]  code;
  logic [34:0] glyph;
  logic [4:0]  row_bits;
  logic        lit;
  logic        tv_d, tv_q;
  logic        pix_d, pix_q;
  logic [11:0] color_d, color_q;

  // S2: fetch the slot's char, pick the glyph row and test the column bit.
  always_comb begin
    code  = buf_q[s1_slot_q];
    glyph = font(code);
    unique case (s1_row_q)
      3'd0:    row_bits = glyph[34:30];
      3'd1:    row_bits = glyph[29:25];
      3'd2:    row_bits = glyph[24:20];
      3'd3:    row_bits = glyph[19:15];
      3'd4:    row_bits = glyph[14:10];
      3'd5:    row_bits = glyph[9:5];
      default: row_bits = glyph[4:0];
    endcase
    lit     = s1_hit_q && (code < 6'd36)
           && row_bits[3'd4 - s1_col_q];
    tv_d    = s1_valid_q;
    pix_d   = lit && show;
    color_d = pix_d ? s1_fg_q : 12'h000;
  end

  // S2 output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tv_q    <= 1'b0;
      pix_q   <= 1'b0;
      color_q <= '0;
    end else begin
      tv_q    <= tv_d;
      pix_q   <= pix_d;
      color_q <= color_d;
    end
  end

  assign busy          = busy_q;
  assign text_valid    = tv_q;
  assign is_text_pixel = pix_q;
  assign text_color    = color_q;

endmodule

// File: tb/tb_text_overlay_engine.sv
// tb_text_overlay_engine: vector table plus scoreboard queue for the
// two-cycle pixel pipeline, with clear, same-cycle write, blink and reset cases.
module tb_text_overlay_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_valid;
  logic [9:0]  pixel_x, pixel_y, origin_x, origin_y;
  logic [11:0] fg_color;
  logic        frame_start, wr_en;
  logic [3:0]  wr_addr;
  logic [5:0]  wr_char;
  logic        busy, text_valid, is_text_pixel;
  logic [11:0] text_color;

  text_overlay_engine #(
    .SCALE(3), .MAX_CHARS(16), .AW(4), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .origin_x(origin_x), .origin_y(origin_y),
    .fg_color(fg_color), .frame_start(frame_start),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
    .busy(busy), .text_valid(text_valid),
    .is_text_pixel(is_text_pixel), .text_color(text_color)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [9:0]  x, y, ox, oy;
    logic [11:0] fg;
    logic        fs, we;
    logic [3:0]  wa;
    logic [5:0]  wc;
    logic        lit;
  } vec_t;

  typedef struct {
    logic [13:0] o;
    int          id;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  logic hid;

  function automatic vec_t base();
    vec_t t;
    t.v = 1'b0; t.x = '0; t.y = '0;
    t.ox = 10'd100; t.oy = 10'd50; t.fg = 12'hF00;
    t.fs = 1'b0; t.we = 1'b0; t.wa = '0; t.wc = '0;
    t.lit = 1'b0;
    return t;
  endfunction

  function automatic vec_t px(int x, int y, logic l);
    vec_t t;
    t = base();
    t.v = 1'b1; t.x = 10'(x); t.y = 10'(y); t.lit = l;
    return t;
  endfunction

  function automatic vec_t pxo(int ox, int oy, int x, int y, logic l);
    vec_t t;
    t = px(x, y, l);
    t.ox = 10'(ox); t.oy = 10'(oy);
    return t;
  endfunction

  function automatic vec_t wr(int a, int c);
    vec_t t;
    t = base();
    t.we = 1'b1; t.wa = 4'(a); t.wc = 6'(c);
    return t;
  endfunction

  function automatic vec_t fsp();
    vec_t t;
    t = base();
    t.fs = 1'b1;
    return t;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic idle();
    pix_valid = 1'b0; frame_start = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_char = '0;
  endtask

  task automatic sample_out();
    exp_t e;
    e = sb.pop_front();
    check($sformatf("pix%0d", e.id),
          {18'd0, text_valid, is_text_pixel, text_color},
          {18'd0, e.o});
  endtask

  task automatic step(input vec_t t, input int id);
    exp_t e;
    @(posedge clk); #1;
    if (sb.size() >= 2) sample_out();
    pix_valid = t.v; pixel_x = t.x; pixel_y = t.y;
    origin_x = t.ox; origin_y = t.oy; fg_color = t.fg;
    frame_start = t.fs; wr_en = t.we;
    wr_addr = t.wa; wr_char = t.wc;
    e.o  = {t.v, t.lit, t.lit ? t.fg : 12'h000};
    e.id = id;
    sb.push_back(e);
  endtask

  task automatic drain();
    @(posedge clk); #1;
    idle();
    while (sb.size() > 0) begin
      sample_out();
      if (sb.size() > 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_clear(input string nm);
    int   n;
    logic bad;
    n = 0;
    bad = 1'b0;
    do begin
      @(posedge clk); #1;
      n++;
      if (text_valid || is_text_pixel || text_color != 12'h000)
        bad = 1'b1;
    end while (busy && n < 40);
    check({nm, "_len"}, n, 16);
    check({nm, "_out0"}, {31'd0, bad}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef TEXT_OVERLAY_BLINK_EN
    hid = 1'b1;
`else
    hid = 1'b0;
`endif
    tbl.push_back(px(106, 50, 0));
    tbl.push_back(wr(0, 0));
    tbl.push_back(px(106, 50, 1));
    tbl.push_back(px(100, 50, 0));
    tbl.push_back(px(99, 50, 0));
    tbl.push_back(px(100, 49, 0));
    tbl.push_back(px(100, 71, 0));
    tbl.push_back(px(442, 50, 0));
    tbl.push_back(px(100, 53, 1));
    tbl.push_back(px(112, 53, 1));
    tbl.push_back(px(115, 53, 0));
    tbl.push_back(px(103, 59, 1));
    tbl.push_back(px(103, 56, 0));
    tbl.push_back(px(100, 70, 1));
    tbl.push_back(px(106, 50, 1));
    tbl[14].v = 1'b0;
    tbl[14].lit = 1'b0;
    tbl.push_back(px(127, 50, 0));
    tbl.push_back(wr(1, 1));
    tbl.push_back(px(121, 50, 1));
    tbl[17].fg = 12'h0F0;
    tbl.push_back(wr(15, 27));
    tbl.push_back(px(421, 50, 1));
    tbl.push_back(px(415, 50, 0));
    tbl.push_back(px(435, 50, 0));
    tbl.push_back(wr(2, 40));
    tbl.push_back(px(142, 53, 0));
    tbl.push_back(pxo(0, 0, 6, 0, 1));
    tbl.push_back(pxo(100, 50, 6, 0, 0));
    tbl.push_back(pxo(1020, 50, 5, 50, 0));
    tbl.push_back(pxo(100, 1020, 100, 3, 0));

    reset = 1'b1;
    idle();
    pixel_x = '0; pixel_y = '0;
    origin_x = 10'd100; origin_y = 10'd50; fg_color = 12'hF00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 1);
    check("rst_out",
          {18'd0, text_valid, is_text_pixel, text_color}, 0);

    @(negedge clk);
    reset = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd0; wr_char = 6'd0;
    wait_clear("clear");
    idle();

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);
    drain();

    step(px(103, 59, 1), 100);
    begin
      vec_t t;
      t = px(103, 70, 1);
      t.we = 1'b1; t.wa = 4'd0; t.wc = 6'd14;
      step(t, 101);
    end
    step(px(103, 59, 0), 102);
    drain();

    step(fsp(), 110);
    step(fsp(), 111);
    step(px(106, 50, !hid), 112);
    step(fsp(), 113);
    step(fsp(), 114);
    step(px(106, 50, 1), 115);
    drain();

    step(px(106, 50, 1), 120);
    step(px(106, 50, 1), 121);
    step(px(106, 50, 1), 122);
    @(posedge clk); #1;
    idle();
    sample_out();
    #2;
    reset = 1'b1;
    #1;
    check("midrst_out",
          {18'd0, text_valid, is_text_pixel, text_color}, 0);
    check("midrst_busy", {31'd0, busy}, 1);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    wait_clear("reclear");
    step(px(106, 50, 0), 130);
    step(px(100, 53, 0), 131);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
